// File: rtl/nmi_irq_ctrl.sv
// Interrupt aggregator: synchronises peripheral irqs, latches them as pending, and presents
// a masked, lowest-index-first CPU interrupt with claim/complete over a valid/ready register port.
module nmi_irq_ctrl #(
    parameter int unsigned IRQ_NUM     = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_valid_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [3:0]         mem_wstrb_i,
    output logic [31:0]        mem_rdata_o,
    output logic               mem_ready_o,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               irq_o,
    output logic [4:0]         irq_id_o
);

    typedef enum logic [2:0] {
        REG_PENDING  = 3'd0,
        REG_ENABLE   = 3'd1,
        REG_TYPE     = 3'd2,
        REG_CLAIM    = 3'd3,
        REG_COMPLETE = 3'd4
    } reg_sel_e;

    logic [IRQ_NUM-1:0] r_sync [SYNC_STAGES];
    logic [IRQ_NUM-1:0] r_prev;
    logic [IRQ_NUM-1:0] r_pend;
    logic [IRQ_NUM-1:0] r_en;
    logic [IRQ_NUM-1:0] r_type;
    logic [IRQ_NUM-1:0] r_inserv;
    logic               r_ready;
    logic [31:0]        r_rdata;
    logic               r_irq;
    logic [4:0]         r_id;

    logic [IRQ_NUM-1:0] w_s;
    logic [IRQ_NUM-1:0] w_elig;
    logic [IRQ_NUM-1:0] w_claim_oh;
    logic [IRQ_NUM-1:0] w_cmpl_oh;
    logic [IRQ_NUM-1:0] w_pend_nxt;
    logic [4:0]         w_id;
    logic [31:0]        w_rdata;
    logic               w_access;
    logic               w_write;
    logic               w_claim;
    reg_sel_e           w_sel;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_elig   = r_pend & r_en & ~r_inserv;
    assign w_access = mem_valid_i & ~r_ready;
    assign w_write  = |mem_wstrb_i;
    assign w_sel    = reg_sel_e'(mem_addr_i[4:2]);
    assign w_claim  = w_access & ~w_write & (w_sel == REG_CLAIM) & (r_id != 5'd0);

    assign mem_ready_o = r_ready;
    assign mem_rdata_o = r_rdata;
    assign irq_o       = r_irq;
    assign irq_id_o    = r_id;

    always_comb begin
        w_id       = '0;
        w_claim_oh = '0;
        w_cmpl_oh  = '0;
        w_pend_nxt = r_pend;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            if (w_elig[i] && w_id == 5'd0)
                w_id = 5'(i + 1);
            w_claim_oh[i] = w_claim && (r_id == 5'(i + 1));
            w_cmpl_oh[i]  = w_access && w_write && (w_sel == REG_COMPLETE) && mem_wstrb_i[0]
                            && (mem_wdata_i[4:0] == 5'(i + 1));
            // Level sources mirror the synchroniser; for edge sources a new edge beats a claim.
            if (!r_type[i])
                w_pend_nxt[i] = w_s[i];
            else if (w_s[i] && !r_prev[i])
                w_pend_nxt[i] = 1'b1;
            else if (w_claim_oh[i])
                w_pend_nxt[i] = 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_PENDING:  w_rdata[IRQ_NUM-1:0] = r_pend;
            REG_ENABLE:   w_rdata[IRQ_NUM-1:0] = r_en;
            REG_TYPE:     w_rdata[IRQ_NUM-1:0] = r_type;
            REG_CLAIM:    w_rdata[4:0]         = r_id;
            REG_COMPLETE: w_rdata[IRQ_NUM-1:0] = r_inserv;
            default:      w_rdata              = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                r_sync[k] <= '0;
            r_prev   <= '0;
            r_pend   <= '0;
            r_en     <= '0;
            r_type   <= '0;
            r_inserv <= '0;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            r_id     <= '0;
        end else begin
            r_sync[0] <= irq_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
            r_prev   <= w_s;
            r_pend   <= w_pend_nxt;
            r_inserv <= (r_inserv | w_claim_oh) & ~w_cmpl_oh;
            r_irq    <= |w_elig;
            r_id     <= w_id;
            r_ready  <= w_access;
            r_rdata  <= w_access ? w_rdata : 32'd0;
            for (int unsigned i = 0; i < IRQ_NUM; i++) begin
                if (w_access && mem_wstrb_i[i >> 3]) begin
                    if (w_sel == REG_ENABLE)
                        r_en[i] <= mem_wdata_i[i];
                    if (w_sel == REG_TYPE)
                        r_type[i] <= mem_wdata_i[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_nmi_irq_ctrl.sv
// Directed bench for nmi_irq_ctrl: bus reads are scoreboarded by a separate monitor,
// interrupt outputs are checked at hand-computed points in the sequence.
module tb_nmi_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [5:0]  irq_in;
    logic        irq_out;
    logic [4:0]  irq_id;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t sb[$];

    nmi_irq_ctrl #(.IRQ_NUM(6), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_rdata_o (mem_rdata),
        .mem_ready_o (mem_ready),
        .irq_i       (irq_in),
        .irq_o       (irq_out),
        .irq_id_o    (irq_id)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation per ready pulse; also polices the handshake shape.
    logic prev_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (mem_ready) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ready: ready=1 with no access outstanding");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (mem_rdata !== e.data) begin
                        n_err++;
                        $display("FAIL %s: rdata=0x%08h expected=0x%08h", e.name, mem_rdata, e.data);
                    end
                end
            end
            if (prev_ready) begin
                n_err++;
                $display("FAIL ready_back_to_back: ready high on two consecutive cycles");
            end
        end else if (mem_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rdata_idle: rdata=0x%08h expected=0x00000000 while not ready", mem_rdata);
        end
        prev_ready = mem_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input bit is_chk, input logic [31:0] exp);
        exp_t e;
        bit   got;
        e.chk  = is_chk;
        e.data = exp;
        e.name = name;
        @(negedge clk);
        sb.push_back(e);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) got = 1'b1;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: ready=0 expected=1 within 6 cycles", name);
            void'(sb.pop_back());
        end
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus(name, addr, 32'd0, 4'b0000, 1'b1, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        bus("write", addr, wdata, wstrb, 1'b0, 32'd0);
    endtask

    task automatic pulse(input logic [5:0] bits);
        @(negedge clk);
        irq_in = bits;
        @(negedge clk);
        irq_in = 6'h00;
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        irq_in    = 6'h3F;

        // Reset with all sources high
        wait_cyc(3);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_irq", 32'(irq_out), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(6);
        chk("masked_irq", 32'(irq_out), 32'd0);
        irq_in = 6'h00;
        wait_cyc(6);
        rd("pending_idle", 32'h00, 32'h00);

        // Single edge on source 2: claim and complete
        wr(32'h08, 32'h3F, 4'b0001);
        wr(32'h04, 32'h3F, 4'b0001);
        pulse(6'h04);
        wait_cyc(5);
        chk("irq_src2", 32'(irq_out), 32'd1);
        chk("id_src2", 32'(irq_id), 32'd3);
        rd("pending_src2", 32'h00, 32'h04);
        rd("claim_src2", 32'h0C, 32'd3);
        wait_cyc(2);
        chk("irq_after_claim", 32'(irq_out), 32'd0);
        rd("pending_after_claim", 32'h00, 32'h00);
        rd("inserv_src2", 32'h10, 32'h04);
        wr(32'h10, 32'd3, 4'b0001);
        rd("inserv_cleared", 32'h10, 32'h00);

        // Simultaneous edges on sources 4 and 1
        pulse(6'h12);
        wait_cyc(5);
        chk("id_pair_first", 32'(irq_id), 32'd2);
        rd("claim_src1", 32'h0C, 32'd2);
        wait_cyc(2);
        chk("id_pair_second", 32'(irq_id), 32'd5);
        rd("claim_src4", 32'h0C, 32'd5);
        wait_cyc(2);
        chk("irq_pair_done", 32'(irq_out), 32'd0);
        rd("claim_none", 32'h0C, 32'd0);
        rd("inserv_pair", 32'h10, 32'h12);
        wr(32'h10, 32'd2, 4'b0001);
        wr(32'h10, 32'd5, 4'b0001);
        rd("inserv_pair_cleared", 32'h10, 32'h00);

        // Level source 0 held high across claim/complete
        wr(32'h08, 32'h3E, 4'b0001);
        @(negedge clk);
        irq_in = 6'h01;
        wait_cyc(6);
        chk("id_level", 32'(irq_id), 32'd1);
        rd("claim_level", 32'h0C, 32'd1);
        wait_cyc(2);
        chk("irq_level_inserv", 32'(irq_out), 32'd0);
        rd("pending_level_held", 32'h00, 32'h01);
        wr(32'h10, 32'd1, 4'b0001);
        wait_cyc(3);
        chk("irq_level_reassert", 32'(irq_out), 32'd1);
        chk("id_level_reassert", 32'(irq_id), 32'd1);
        irq_in = 6'h00;
        wait_cyc(6);
        chk("irq_level_released", 32'(irq_out), 32'd0);

        // Edge on source 5 arrives in the claim commit cycle: set wins
        pulse(6'h20);
        wait_cyc(5);
        chk("id_src5", 32'(irq_id), 32'd6);
        @(negedge clk);
        irq_in = 6'h20;
        @(negedge clk);
        rd("claim_src5", 32'h0C, 32'd6);
        irq_in = 6'h00;
        rd("pending_src5_kept", 32'h00, 32'h20);
        chk("irq_src5_inserv", 32'(irq_out), 32'd0);
        wr(32'h10, 32'd6, 4'b0001);
        wait_cyc(3);
        chk("irq_src5_reassert", 32'(irq_out), 32'd1);
        chk("id_src5_reassert", 32'(irq_id), 32'd6);
        rd("claim_src5_again", 32'h0C, 32'd6);
        wr(32'h10, 32'd6, 4'b0001);

        // Strobes, unmapped offset, bad COMPLETE ids
        wr(32'h04, 32'h00, 4'b0010);
        rd("enable_strobe", 32'h04, 32'h3F);
        rd("unmapped", 32'h14, 32'h00);
        wr(32'h00, 32'hFF, 4'b1111);
        rd("pending_ro", 32'h00, 32'h00);
        pulse(6'h08);
        wait_cyc(5);
        rd("claim_src3", 32'h0C, 32'd4);
        wr(32'h10, 32'd0, 4'b0001);
        wr(32'h10, 32'd7, 4'b0001);
        wr(32'h10, 32'h0400, 4'b0010);
        rd("inserv_bad_complete", 32'h10, 32'h08);
        wr(32'h10, 32'd4, 4'b0001);
        rd("inserv_src3_cleared", 32'h10, 32'h00);

        // ENABLE cleared while pending: bit retained, irq drops
        pulse(6'h04);
        wait_cyc(5);
        chk("irq_before_mask", 32'(irq_out), 32'd1);
        wr(32'h04, 32'h3B, 4'b0001);
        wait_cyc(2);
        chk("irq_masked", 32'(irq_out), 32'd0);
        rd("pending_retained", 32'h00, 32'h04);
        wr(32'h04, 32'h3F, 4'b0001);
        wait_cyc(2);
        chk("id_unmasked", 32'(irq_id), 32'd3);
        rd("claim_unmasked", 32'h0C, 32'd3);
        wr(32'h10, 32'd3, 4'b0001);

        // Reset mid-access: no ack, registers cleared
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = 32'h04;
        mem_wstrb = 4'b0000;
        rst       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            chk("rst_midaccess_ready", 32'(mem_ready), 32'd0);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        rst       = 1'b0;
        rd("enable_after_rst", 32'h04, 32'h00);
        rd("type_after_rst", 32'h08, 32'h00);
        rd("inserv_after_rst", 32'h10, 32'h00);
        wait_cyc(2);

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
